cond_status_unit: RTL and testbench

//  Status register and condition evaluator directly downstream of the ALU.
//  - Latches ALU flags {N,Z,C,V} when the execute-stage instruction has its S bit set.
//  - Evaluates the 4-bit condition field of the decode-stage instruction against the flags.
//  - Feeds the registered carry back to ALU Cin.
//  - Resolves the flag hazard (flag setter in execute, conditional in decode) by forwarding or by a 1-cycle stall.

---
 rtl/cond_pkg.sv | 32 +++
 rtl/cond_eval.sv | 40 ++++
 rtl/cond_status_unit.sv | 93 +++++++++
 tb/tb_cond_status_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the condition/status unit: condition codes, flag bit
// positions inside {N,Z,C,V}, and the hazard FSM state encoding.
package cond_pkg;

    localparam logic [3:0] EQ = 4'd0;
    localparam logic [3:0] NE = 4'd1;
    localparam logic [3:0] CS = 4'd2;
    localparam logic [3:0] CC = 4'd3;
    localparam logic [3:0] MI = 4'd4;
    localparam logic [3:0] PL = 4'd5;
    localparam logic [3:0] VS = 4'd6;
    localparam logic [3:0] VC = 4'd7;
    localparam logic [3:0] HI = 4'd8;
    localparam logic [3:0] LS = 4'd9;
    localparam logic [3:0] GE = 4'd10;
    localparam logic [3:0] LT = 4'd11;
    localparam logic [3:0] GT = 4'd12;
    localparam logic [3:0] LE = 4'd13;
    localparam logic [3:0] AL = 4'd14;
    localparam logic [3:0] NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition evaluator: decides whether a 4-bit condition
// holds for a given {N,Z,C,V} flag set. Shared with the branch unit.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            EQ: pass = z;
            NE: pass = !z;
            CS: pass = c;
            CC: pass = !c;
            MI: pass = n;
            PL: pass = !n;
            VS: pass = v;
            VC: pass = !v;
            HI: pass = c & !z;
            LS: pass = !c | z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = !z & (n == v);
            LE: pass = z | (n != v);
            AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_status_unit.sv
// Status register + condition evaluator behind the ALU, with flag-hazard handling.
// Define COND_FLAG_FWD_EN to forward ALU flags instead of stalling one cycle.
module cond_status_unit
    import cond_pkg::*;
#(
    parameter logic [3:0] CC_RESET = 4'b0000,
    parameter int         COND_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              flag_we,
    input  logic [COND_W-1:0] cond,
    input  logic              cond_valid,
    input  logic              flush,
    output logic [3:0]        flags,
    output logic              carry_out,
    output logic              cond_true,
    output logic              stall
);

`ifdef COND_FLAG_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [3:0] flags_p1;
    logic [3:0] alu_flags;
    logic [3:0] eval_flags;
    logic       hz;
    logic       use_fwd;
    logic       pass;
    state_t     state, state_nxt;

    assign alu_flags = {alu_n, alu_z, alu_c, alu_v};
    assign hz        = cond_valid & flag_we & (cond != AL) & (cond != NV);

    // Execute -> status register boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_p1 <= CC_RESET;
        end else if (flag_we) begin
            flags_p1 <= alu_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        stall     = 1'b0;
        use_fwd   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (FWD_EN) begin
                    use_fwd = hz;
                end else begin
                    stall = hz;
                    // A flushed hazard still stalls this cycle but never enters HOLD.
                    if (hz && !flush) begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign eval_flags = use_fwd ? alu_flags : flags_p1;

    cond_eval u_cond_eval (
        .cond  (cond[3:0]),
        .flags (eval_flags),
        .pass  (pass)
    );

    assign cond_true = cond_valid & !stall & pass;
    assign flags     = flags_p1;
    assign carry_out = flags_p1[FLAG_C];

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed bench for cond_status_unit: reset, flag capture, condition table,
// hazard stall/forwarding, flush and reset-in-HOLD sequences.
module tb_cond_status_unit;
    import cond_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       flag_we;
    logic [3:0] cond;
    logic       cond_valid;
    logic       flush;
    logic [3:0] flags, flags_b;
    logic       carry_out, carry_out_b;
    logic       cond_true, cond_true_b;
    logic       stall, stall_b;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [3:0] c;
        logic [3:0] f;
        logic       exp;
    } vec_t;

    vec_t tbl[20];

    cond_status_unit #(.CC_RESET(4'b0000), .COND_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .flag_we(flag_we), .cond(cond), .cond_valid(cond_valid), .flush(flush),
        .flags(flags), .carry_out(carry_out), .cond_true(cond_true), .stall(stall)
    );

    cond_status_unit #(.CC_RESET(4'b0010), .COND_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .flag_we(flag_we), .cond(cond), .cond_valid(cond_valid), .flush(flush),
        .flags(flags_b), .carry_out(carry_out_b), .cond_true(cond_true_b), .stall(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_alu(input logic [3:0] f);
        {alu_n, alu_z, alu_c, alu_v} = f;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        after_edge();
        cond_valid = 1'b0;
        flag_we    = 1'b1;
        set_alu(f);
        after_edge();
        flag_we    = 1'b0;
    endtask

    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return ~z;
            4'd2:  return cy;
            4'd3:  return ~cy;
            4'd4:  return n;
            4'd5:  return ~n;
            4'd6:  return v;
            4'd7:  return ~v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return !(n ^ v);
            4'd11: return n ^ v;
            4'd12: return !z && !(n ^ v);
            4'd13: return z || (n ^ v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; flag_we = 1'b0; cond = EQ; cond_valid = 1'b0; flush = 1'b0;
        set_alu(4'b0000);

        tbl[0]  = '{EQ, 4'b0100, 1'b1};
        tbl[1]  = '{NE, 4'b0100, 1'b0};
        tbl[2]  = '{CS, 4'b0010, 1'b1};
        tbl[3]  = '{CC, 4'b0010, 1'b0};
        tbl[4]  = '{MI, 4'b1000, 1'b1};
        tbl[5]  = '{PL, 4'b1000, 1'b0};
        tbl[6]  = '{VS, 4'b0001, 1'b1};
        tbl[7]  = '{VC, 4'b0001, 1'b0};
        tbl[8]  = '{HI, 4'b0010, 1'b1};
        tbl[9]  = '{HI, 4'b0110, 1'b0};
        tbl[10] = '{LS, 4'b0000, 1'b1};
        tbl[11] = '{GE, 4'b1000, 1'b0};
        tbl[12] = '{LT, 4'b1000, 1'b1};
        tbl[13] = '{GT, 4'b0000, 1'b1};
        tbl[14] = '{GT, 4'b1001, 1'b1};
        tbl[15] = '{GT, 4'b1000, 1'b0};
        tbl[16] = '{LE, 4'b0100, 1'b1};
        tbl[17] = '{LE, 4'b0001, 1'b1};
        tbl[18] = '{AL, 4'b0000, 1'b1};
        tbl[19] = '{NV, 4'b1111, 1'b0};

        // Reset values and mid-cycle asynchronous reset
        #12;
        chk("reset_flags", flags, 4'b0000);
        chk("reset_carry", {3'b0, carry_out}, 4'b0000);
        chk("reset_stall", {3'b0, stall}, 4'b0000);
        chk("reset_cond_true", {3'b0, cond_true}, 4'b0000);
        chk("reset_b_carry", {3'b0, carry_out_b}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Flag capture and hold
        after_edge();
        flag_we = 1'b1;
        set_alu(4'b0110);
        after_edge();
        chk("capture_flags", flags, 4'b0110);
        chk("capture_carry", {3'b0, carry_out}, 4'b0001);
        flag_we = 1'b0;
        set_alu(4'b1001);
        after_edge();
        chk("hold_flags", flags, 4'b0110);

        // Asynchronous reset mid-cycle clears a written register
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", flags, 4'b0000);
        chk("async_rst_b_flags", flags_b, 4'b0010);
        chk("async_rst_b_carry", {3'b0, carry_out_b}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed condition table
        for (int i = 0; i < 20; i++) begin
            load_flags(tbl[i].f);
            cond = tbl[i].c;
            cond_valid = 1'b1;
            #1;
            chk($sformatf("tbl%0d_flags", i), flags, tbl[i].f);
            chk($sformatf("tbl%0d_cond%0d", i, tbl[i].c), {3'b0, cond_true}, {3'b0, tbl[i].exp});
        end

        // Full sweep of flags x conditions
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            cond_valid = 1'b1;
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1;
                chk($sformatf("sweep_f%0d_c%0d", f, c), {3'b0, cond_true}, {3'b0, ref_eval(4'(c), 4'(f))});
            end
        end

        // cond_valid low gates the outcome
        cond = AL;
        cond_valid = 1'b0;
        #1;
        chk("invalid_al", {3'b0, cond_true}, 4'b0000);

        load_flags(4'b0000);
`ifdef COND_FLAG_FWD_EN
        // Forwarded flags resolve the hazard in the same cycle
        flag_we = 1'b1; set_alu(4'b0100); cond = EQ; cond_valid = 1'b1;
        #1;
        chk("fwd_eq_stall", {3'b0, stall}, 4'b0000);
        chk("fwd_eq_true", {3'b0, cond_true}, 4'b0001);
        cond = NE;
        #1;
        chk("fwd_ne_true", {3'b0, cond_true}, 4'b0000);
        after_edge();
        chk("fwd_flags", flags, 4'b0100);
        set_alu(4'b0000); cond = EQ;
        #1;
        chk("fwd_back2back_stall", {3'b0, stall}, 4'b0000);
        chk("fwd_back2back_true", {3'b0, cond_true}, 4'b0000);
        after_edge();
        flag_we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("fwd_rst_flags", flags, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
        cond = EQ; cond_valid = 1'b1;
        #1;
        chk("fwd_post_rst_eq", {3'b0, cond_true}, 4'b0000);
`else
        // Hazard: one-cycle stall, decision from the freshly written flags
        flag_we = 1'b1; set_alu(4'b0100); cond = EQ; cond_valid = 1'b1;
        #1;
        chk("hz_stall", {3'b0, stall}, 4'b0001);
        chk("hz_true", {3'b0, cond_true}, 4'b0000);
        after_edge();
        flag_we = 1'b0;
        #1;
        chk("hold_stall", {3'b0, stall}, 4'b0000);
        chk("hold_true", {3'b0, cond_true}, 4'b0001);
        after_edge();
        flag_we = 1'b1; set_alu(4'b0000); cond = AL;
        #1;
        chk("al_no_stall", {3'b0, stall}, 4'b0000);
        chk("al_true", {3'b0, cond_true}, 4'b0001);

        // Flush during a hazard stalls but keeps the FSM in IDLE
        cond = EQ; flush = 1'b1;
        #1;
        chk("flush_hz_stall", {3'b0, stall}, 4'b0001);
        after_edge();
        flush = 1'b0; set_alu(4'b0100);
        #1;
        chk("post_flush_stall", {3'b0, stall}, 4'b0001);
        after_edge();
        // Unexpected write in HOLD: evaluated on pre-update flags, register still updates
        set_alu(4'b0000);
        #1;
        chk("hold_we_stall", {3'b0, stall}, 4'b0000);
        chk("hold_we_true", {3'b0, cond_true}, 4'b0001);
        after_edge();
        flag_we = 1'b0;
        #1;
        chk("hold_we_flags", flags, 4'b0000);

        // Reset while in HOLD
        after_edge();
        flag_we = 1'b1; set_alu(4'b0100); cond = EQ; cond_valid = 1'b1;
        after_edge();
        flag_we = 1'b0;
        #1;
        chk("pre_rst_hold_true", {3'b0, cond_true}, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("hold_rst_flags", flags, 4'b0000);
        chk("hold_rst_stall", {3'b0, stall}, 4'b0000);
        chk("hold_rst_b_flags", flags_b, 4'b0010);
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
        #1;
        chk("post_rst_eq", {3'b0, cond_true}, 4'b0000);
        flag_we = 1'b1; set_alu(4'b0100);
        #1;
        chk("post_rst_idle_stall", {3'b0, stall}, 4'b0001);
        after_edge();
        flag_we = 1'b0;
`endif

        after_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
